// File: rtl/traffic_pkg.sv
// Shared phase encodings, default timings and lamp decode for the intersection scheduler.
// Phase codes double as the debug/LED value driven on the phase output.
package traffic_pkg;

    typedef enum logic [2:0] {
        PH_AR_S2M = 3'd0,
        PH_MGRN   = 3'd1,
        PH_MYEL   = 3'd2,
        PH_AR_M2S = 3'd3,
        PH_SGRN   = 3'd4,
        PH_SYEL   = 3'd5,
        PH_WALK   = 3'd6
    } phase_e;

    localparam int DEF_T_MG_MIN = 8;
    localparam int DEF_T_Y      = 3;
    localparam int DEF_T_AR     = 2;
    localparam int DEF_T_SG     = 5;
    localparam int DEF_T_SG_MAX = 10;
    localparam int DEF_T_WALK   = 6;

    localparam int TW = $clog2(DEF_T_SG_MAX) + 1;

    typedef struct packed {
        logic mr;
        logic my;
        logic mg;
        logic sr;
        logic sy;
        logic sg;
        logic walk;
    } lamps_t;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Both roads default to red; each phase lights exactly one replacement lamp.
    function automatic lamps_t lamp_decode(input phase_e ph);
        lamps_t l;
        l    = '0;
        l.mr = 1'b1;
        l.sr = 1'b1;
        case (ph)
            PH_MGRN: begin l.mr = 1'b0; l.mg = 1'b1; end
            PH_MYEL: begin l.mr = 1'b0; l.my = 1'b1; end
            PH_SGRN: begin l.sr = 1'b0; l.sg = 1'b1; end
            PH_SYEL: begin l.sr = 1'b0; l.sy = 1'b1; end
            PH_WALK: l.walk = 1'b1;
            default: ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase cycle counter: synchronous clear, saturating increment, async reset.
// Saturation keeps long main-green holds from wrapping back into timing windows.
module phase_timer #(
    parameter int W   = 5,
    parameter int SAT = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] SAT_V = W'(SAT);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (cnt_q != SAT_V) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-driven main/side light sequencer with pedestrian walk phase and emergency preempt.
// Lamps are registered from the next phase, so they change on the same edge as the phase.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int T_MG_MIN = DEF_T_MG_MIN,
    parameter int T_Y      = DEF_T_Y,
    parameter int T_AR     = DEF_T_AR,
    parameter int T_SG     = DEF_T_SG,
    parameter int T_SG_MAX = DEF_T_SG_MAX,
    parameter int T_WALK   = DEF_T_WALK
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       side_req,
    input  logic       ped_req,
    input  logic       emg,
    output logic       MR,
    output logic       MY,
    output logic       MG,
    output logic       SR,
    output logic       SY,
    output logic       SG,
    output logic       WALK,
    output logic [2:0] phase
);

    localparam int T_MAX = imax(imax(imax(T_MG_MIN, T_Y), imax(T_AR, T_SG)),
                                imax(T_SG_MAX, T_WALK));
    localparam int TMR_W = $clog2(T_MAX) + 1;

    localparam logic [TMR_W-1:0] MG_END   = TMR_W'(T_MG_MIN - 1);
    localparam logic [TMR_W-1:0] Y_END    = TMR_W'(T_Y - 1);
    localparam logic [TMR_W-1:0] AR_END   = TMR_W'(T_AR - 1);
    localparam logic [TMR_W-1:0] SG_END   = TMR_W'(T_SG - 1);
    localparam logic [TMR_W-1:0] SGMX_END = TMR_W'(T_SG_MAX - 1);
    localparam logic [TMR_W-1:0] WALK_END = TMR_W'(T_WALK - 1);

    phase_e             state_q, state_d;
    logic               ped_pend_q, ped_pend_d;
    lamps_t             lamps_q;
    logic [TMR_W-1:0]   tmr;
    logic               enter_walk;

    phase_timer #(
        .W   (TMR_W),
        .SAT (T_MAX)
    ) u_phase_timer (
        .clk   (clk),
        .rst   (rst),
        .clr_i (state_d != state_q),
        .cnt_o (tmr)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            PH_AR_S2M: if (tmr == AR_END) state_d = PH_MGRN;
            PH_MGRN:   if (tmr >= MG_END && (side_req || ped_pend_q) && !emg) state_d = PH_MYEL;
            PH_MYEL:   if (tmr == Y_END) state_d = PH_AR_M2S;
            // Once clearance ends the side road is served even if its car left.
            PH_AR_M2S: if (tmr == AR_END) begin
                if (emg)             state_d = PH_AR_S2M;
                else if (ped_pend_q) state_d = PH_WALK;
                else                 state_d = PH_SGRN;
            end
            PH_WALK:   if (tmr == WALK_END) state_d = (side_req && !emg) ? PH_SGRN : PH_AR_S2M;
            PH_SGRN:   if (emg || tmr == SGMX_END || (tmr >= SG_END && !side_req)) state_d = PH_SYEL;
            PH_SYEL:   if (tmr == Y_END) state_d = PH_AR_S2M;
            default:   state_d = PH_AR_S2M;
        endcase
    end

    assign enter_walk = (state_d == PH_WALK) && (state_q != PH_WALK);
    assign ped_pend_d = ped_req || (ped_pend_q && !enter_walk);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= PH_AR_S2M;
            ped_pend_q <= 1'b0;
            lamps_q    <= lamp_decode(PH_AR_S2M);
        end else begin
            state_q    <= state_d;
            ped_pend_q <= ped_pend_d;
            lamps_q    <= lamp_decode(state_d);
        end
    end

    assign MR    = lamps_q.mr;
    assign MY    = lamps_q.my;
    assign MG    = lamps_q.mg;
    assign SR    = lamps_q.sr;
    assign SY    = lamps_q.sy;
    assign SG    = lamps_q.sg;
    assign WALK  = lamps_q.walk;
    assign phase = state_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler: phase lengths, lamp patterns, ped/emg/reset cases.
module tb_traffic_phase_scheduler;

    localparam logic [2:0] P_AR_S2M = 3'd0;
    localparam logic [2:0] P_MGRN   = 3'd1;
    localparam logic [2:0] P_MYEL   = 3'd2;
    localparam logic [2:0] P_AR_M2S = 3'd3;
    localparam logic [2:0] P_SGRN   = 3'd4;
    localparam logic [2:0] P_SYEL   = 3'd5;
    localparam logic [2:0] P_WALK   = 3'd6;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       side_req = 1'b0;
    logic       ped_req  = 1'b0;
    logic       emg      = 1'b0;
    logic       MR, MY, MG, SR, SY, SG, WALK;
    logic [2:0] phase;
    logic [6:0] lamps;

    int n_cmp = 0;
    int n_bad = 0;

    traffic_phase_scheduler dut (
        .clk      (clk),
        .rst      (rst),
        .side_req (side_req),
        .ped_req  (ped_req),
        .emg      (emg),
        .MR       (MR),
        .MY       (MY),
        .MG       (MG),
        .SR       (SR),
        .SY       (SY),
        .SG       (SG),
        .WALK     (WALK),
        .phase    (phase)
    );

    assign lamps = {MR, MY, MG, SR, SY, SG, WALK};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // {MR,MY,MG,SR,SY,SG,WALK} expected for each phase code
    function automatic logic [6:0] exp_lamps(input logic [2:0] ph);
        case (ph)
            P_MGRN:  return 7'b0011000;
            P_MYEL:  return 7'b0101000;
            P_SGRN:  return 7'b1000010;
            P_SYEL:  return 7'b1000100;
            P_WALK:  return 7'b1001001;
            default: return 7'b1001000;
        endcase
    endfunction

    // Checks phase/lamps now, then counts samples until the phase changes (bounded).
    task automatic run_phase(input string tag, input logic [2:0] ph, input int exp_n, input int max_n);
        int n;
        n = 0;
        chk({tag, "_ph"}, 32'(phase), 32'(ph));
        chk({tag, "_lamp"}, 32'(lamps), 32'(exp_lamps(ph)));
        while (phase == ph && n < max_n) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_len"}, n, exp_n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, no requests
        #1 rst = 1'b1;
        #1;
        chk("rst_async_lamp", 32'(lamps), 32'(7'b1001000));
        @(negedge clk);
        chk("rst_lamp", 32'(lamps), 32'(7'b1001000));
        chk("rst_ph", 32'(phase), 32'(P_AR_S2M));
        chk("rst_ped", 32'(dut.ped_pend_q), 0);
        @(negedge clk);
        rst = 1'b0;
        run_phase("boot_ar", P_AR_S2M, 2, 10);
        run_phase("idle_mg", P_MGRN, 100, 100);

        // Side demand held: full cycle with max side green, then main minimum
        side_req = 1'b1;
        @(negedge clk);
        run_phase("c1_my", P_MYEL,   3, 10);
        run_phase("c1_ar", P_AR_M2S, 2, 10);
        run_phase("c1_sg", P_SGRN,  10, 20);
        run_phase("c1_sy", P_SYEL,   3, 10);
        run_phase("c1_ar2", P_AR_S2M, 2, 10);
        run_phase("c2_mg", P_MGRN,   8, 20);
        run_phase("c2_my", P_MYEL,   3, 10);
        run_phase("c2_ar", P_AR_M2S, 2, 10);

        // Short side demand: drop at SG tmr=2, SG totals 5 cycles
        chk("short_sg_ph", 32'(phase), 32'(P_SGRN));
        @(negedge clk);
        @(negedge clk);
        side_req = 1'b0;
        run_phase("short_sg_rest", P_SGRN, 3, 20);
        run_phase("short_sy", P_SYEL,   3, 10);
        run_phase("short_ar", P_AR_S2M, 2, 10);

        // Pedestrian pulse during MG with side demand
        chk("ped_mg_ph", 32'(phase), 32'(P_MGRN));
        side_req = 1'b1;
        ped_req  = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        chk("ped_latched", 32'(dut.ped_pend_q), 1);
        run_phase("ped_mg", P_MGRN,   7, 20);
        run_phase("ped_my", P_MYEL,   3, 10);
        run_phase("ped_ar", P_AR_M2S, 2, 10);
        chk("ped_cleared", 32'(dut.ped_pend_q), 0);
        run_phase("ped_walk", P_WALK, 6, 20);

        // Emergency at SG tmr=1: SY next edge, then MG held despite side demand
        chk("emg_sg_ph", 32'(phase), 32'(P_SGRN));
        @(negedge clk);
        emg = 1'b1;
        @(negedge clk);
        run_phase("emg_sy", P_SYEL,   3, 10);
        run_phase("emg_ar", P_AR_S2M, 2, 10);
        run_phase("emg_hold", P_MGRN, 20, 20);
        emg = 1'b0;
        @(negedge clk);
        run_phase("emg_rel_my", P_MYEL, 3, 10);
        run_phase("emg_rel_ar", P_AR_M2S, 2, 10);

        // Async reset between edges during SG
        chk("arst_sg_ph", 32'(phase), 32'(P_SGRN));
        #2 rst = 1'b1;
        #1;
        chk("arst_lamp", 32'(lamps), 32'(7'b1001000));
        chk("arst_ph", 32'(phase), 32'(P_AR_S2M));
        @(negedge clk);
        rst = 1'b0;
        run_phase("post_ar", P_AR_S2M, 2, 10);
        run_phase("post_mg", P_MGRN,   8, 20);
        run_phase("post_my", P_MYEL,   3, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
